// File: rtl/bitop_pipe.sv
// bitop_pipe: two-stage valid/ready pipeline applying a selectable bitwise operation to two operands
module bitop_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] op_count
);
  logic             r_v1, r_v2;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             w_out_xfer, w_s2_free, w_adv, w_in_xfer;
  logic [WIDTH-1:0] w_calc;
  assign w_out_xfer = r_v2 & out_ready;
  assign w_s2_free  = !r_v2 | out_ready;
  assign w_adv      = r_v1 & w_s2_free;
  assign in_ready   = !r_v1 | w_adv;
  assign w_in_xfer  = in_valid & in_ready;
  assign out_valid  = r_v2;
  assign result     = r_res;
  assign op_count   = r_cnt;
  always_comb begin
    w_calc = r_op == 3'd0 ? r_a & r_b
           : r_op == 3'd1 ? r_a | r_b
           : r_op == 3'd2 ? r_a ^ r_b
           : r_op == 3'd3 ? ~(r_a & r_b)
           : r_op == 3'd4 ? ~(r_a | r_b)
           : r_op == 3'd5 ? ~(r_a ^ r_b)
           : r_op == 3'd6 ? r_a & ~r_b
           : r_a;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      r_v1 <= w_in_xfer | (r_v1 & !w_adv);
      r_v2 <= w_adv | (r_v2 & !out_ready);
      if (w_in_xfer) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
      if (w_adv) r_res <= w_calc;
      if (w_out_xfer && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bitop_pipe.sv
// tb_bitop_pipe: directed self-checking bench for bitop_pipe
module tb_bitop_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [7:0]  a, b, result;
  logic [15:0] op_count;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [2:0]  s_op;
  logic [7:0]  s_a, s_b, s_result;
  logic [1:0]  s_op_count;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_ops [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
  logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  always #5 clk = ~clk;
  bitop_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .op_count(op_count)
  );
  bitop_pipe #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result), .op_count(s_op_count)
  );
  task automatic test_reset;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_ops;
    out_ready = 1'b1;
    a = 8'hF0;
    b = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 8);
      op = 3'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ops_in_ready[%0d]: got %b want 1", k, in_ready); end
      checks++; if (out_valid !== (k >= 2)) begin errors++; $display("FAIL ops_out_valid[%0d]: got %b want %b", k, out_valid, k >= 2); end
      if (k >= 2) begin
        checks++; if (result !== exp_ops[k-2]) begin errors++; $display("FAIL ops_result[%0d]: got %h want %h", k - 2, result, exp_ops[k-2]); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ops_drained: got %b want 0", out_valid); end
    checks++; if (op_count !== 16'd8) begin errors++; $display("FAIL ops_count: got %0d want 8", op_count); end
    @(posedge clk); #1;
  endtask
  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    op = 3'd1;
    @(posedge clk); #1;
    op = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (result !== 8'hFF) begin errors++; $display("FAIL bp_result[%0d]: got %h want ff", k, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      checks++; if (op_count !== 16'd8) begin errors++; $display("FAIL bp_count[%0d]: got %0d want 8", k, op_count); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1; #1;
    checks++; if (out_valid !== 1'b1 || result !== 8'h00) begin errors++; $display("FAIL bp_second: got v=%b r=%h want v=1 r=00", out_valid, result); end
    @(posedge clk); #1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
    checks++; if (op_count !== 16'd10) begin errors++; $display("FAIL bp_count_end: got %0d want 10", op_count); end
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back;
    int acc = 0;
    int del = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd7;
    b = 8'h00;
    a = 8'h10;
    @(posedge clk); #1;
    a = 8'h11;
    @(posedge clk); #1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a = 8'(8'h12 + k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || result !== 8'(8'h10 + k)) begin errors++; $display("FAIL b2b_out[%0d]: got v=%b r=%h want v=1 r=%h", k, out_valid, result, 8'(8'h10 + k)); end
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) del++;
      @(posedge clk); #1;
    end
    checks++; if (acc != 10 || del != 10) begin errors++; $display("FAIL b2b_counts: got acc=%0d del=%0d want 10 10", acc, del); end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || result !== 8'(8'h1A + k)) begin errors++; $display("FAIL b2b_drain[%0d]: got v=%b r=%h want v=1 r=%h", k, out_valid, result, 8'(8'h1A + k)); end
      @(posedge clk); #1;
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    checks++; if (op_count !== 16'd22) begin errors++; $display("FAIL b2b_count: got %0d want 22", op_count); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd7;
    a = 8'h5A;
    @(posedge clk); #1;
    a = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || op_count !== 16'd22) begin errors++; $display("FAIL rm_pre: got v=%b cnt=%0d want v=1 cnt=22", out_valid, op_count); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL rm_op_count: got %0d want 0", op_count); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rm_result: got %h want 00", result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    a = 8'h77;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_first_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_stale: got %b want 0", out_valid); end
    @(posedge clk); #1; #1;
    checks++; if (out_valid !== 1'b1 || result !== 8'h77) begin errors++; $display("FAIL rm_first_result: got v=%b r=%h want v=1 r=77", out_valid, result); end
    @(posedge clk); #1; #1;
    checks++; if (out_valid !== 1'b0 || op_count !== 16'd1) begin errors++; $display("FAIL rm_after: got v=%b cnt=%0d want v=0 cnt=1", out_valid, op_count); end
    @(posedge clk); #1;
  endtask
  task automatic test_saturation;
    s_out_ready = 1'b1;
    s_a = 8'h81;
    s_b = 8'h18;
    s_op = 3'd2;
    for (int k = 0; k < 7; k++) begin
      s_in_valid = (k < 5);
      @(posedge clk); #1;
      if (k >= 2) begin
        checks++; if (s_op_count !== sat_exp[k-2]) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", k - 2, s_op_count, sat_exp[k-2]); end
      end
    end
    s_in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = 3'd0;
    a = 8'h00;
    b = 8'h00;
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    s_op = 3'd0;
    s_a = 8'h00;
    s_b = 8'h00;
    test_reset;
    test_ops;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
